intr_sched: RTL

Interrupt scheduler for the CPU control section: arbitrates NMI and maskable INT requests against the instruction stream. It grants the next fetch slot to the winning request at an instruction boundary. It owns the IFF1/IFF2 flip-flops and the interrupt mode, and tells the sequencer when to run an acknowledge M-cycle instead of a normal opcode fetch. It sits beside the reset block, downstream of the pin logic, and feeds the sequencer and PC load path.

---
 rtl/intr_pkg.sv | 22 ++
 rtl/nmi_edge.sv | 29 ++
 rtl/intr_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt scheduler.
package intr_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ACK_NMI = 2'd1,
        ACK_INT = 2'd2
    } intr_state_t;

    localparam logic [15:0] VEC_NMI = 16'h0066;
    localparam logic [15:0] VEC_IM1 = 16'h0038;

    localparam logic [1:0] IM0 = 2'd0;
    localparam logic [1:0] IM1 = 2'd1;
    localparam logic [1:0] IM2 = 2'd2;

    // Mode 3 does not exist on this CPU; it behaves as mode 2.
    function automatic logic [1:0] clamp_im(input logic [1:0] v);
        return (v == 2'd3) ? IM2 : v;
    endfunction

endpackage

// File: rtl/nmi_edge.sv
// NMI rising-edge detector with a pending latch that is cleared on acceptance.
// Only compiled when INTR_SCHED_NMI_EN is defined.
`ifdef INTR_SCHED_NMI_EN
module nmi_edge (
    input  logic clk,
    input  logic rst,
    input  logic nmi,
    input  logic clr,
    output logic pend
);

    logic nmi_q;

    // A new edge wins over a same-cycle clear so a back-to-back NMI is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            nmi_q <= nmi;
            if (nmi && !nmi_q)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/intr_sched.sv
// Interrupt scheduler: arbitrates NMI and INT at instruction boundaries,
// owns IFF1/IFF2 and the interrupt mode, and drives the acknowledge cycle.
// Optional feature macro: INTR_SCHED_NMI_EN enables the NMI path and RETN.
module intr_sched
    import intr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        nmi,
    input  logic        intr,
    input  logic        insn_end,
    input  logic        ei,
    input  logic        di,
    input  logic        retn,
    input  logic        im_set,
    input  logic [1:0]  im_val,
    input  logic        ack_done,
    output logic        nmi_ack,
    output logic        int_ack,
    output logic        iff1,
    output logic        iff2,
    output logic [1:0]  im,
    output logic        vec_load,
    output logic [15:0] vec,
    output logic        halt_exit
);

    intr_state_t state;
    intr_state_t state_next;
    logic        nmi_pend;
    logic        take_nmi;
    logic        take_int;
    logic        ei_shadow;
    logic        int_blocked;

`ifdef INTR_SCHED_NMI_EN
    nmi_edge u_nmi_edge (
        .clk  (clk),
        .rst  (reset),
        .nmi  (nmi),
        .clr  (take_nmi),
        .pend (nmi_pend)
    );
    assign nmi_ack = (state == ACK_NMI);
`else
    logic unused_nmi_inputs;
    assign unused_nmi_inputs = nmi ^ retn;
    assign nmi_pend = 1'b0;
    assign nmi_ack  = 1'b0;
`endif

    assign int_ack = (state == ACK_INT);

    // An EI strobe in the current cycle also blocks INT, so the EI
    // instruction's own boundary can never accept a maskable interrupt.
    assign int_blocked = ei | ei_shadow;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // Arbitration at instruction boundaries and return on ack_done.
    always_comb begin
        state_next = state;
        take_nmi   = 1'b0;
        take_int   = 1'b0;
        case (state)
            RUN: begin
                if (insn_end) begin
                    if (nmi_pend) begin
                        take_nmi   = 1'b1;
                        state_next = ACK_NMI;
                    end else if (intr && iff1 && !int_blocked) begin
                        take_int   = 1'b1;
                        state_next = ACK_INT;
                    end
                end
            end
            ACK_NMI, ACK_INT: begin
                if (ack_done)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Enable flip-flops, vector outputs and pulses; acceptance overrides EI/DI/RETN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iff1      <= 1'b0;
            iff2      <= 1'b0;
            vec       <= 16'h0000;
            vec_load  <= 1'b0;
            halt_exit <= 1'b0;
        end else begin
            vec_load  <= 1'b0;
            halt_exit <= 1'b0;
            if (take_nmi) begin
                iff2      <= iff1;
                iff1      <= 1'b0;
                vec       <= VEC_NMI;
                vec_load  <= 1'b1;
                halt_exit <= 1'b1;
            end else if (take_int) begin
                iff1      <= 1'b0;
                iff2      <= 1'b0;
                halt_exit <= 1'b1;
                if (im == IM1) begin
                    vec      <= VEC_IM1;
                    vec_load <= 1'b1;
                end
            end else if (di) begin
                iff1 <= 1'b0;
                iff2 <= 1'b0;
            end else if (ei) begin
                iff1 <= 1'b1;
                iff2 <= 1'b1;
`ifdef INTR_SCHED_NMI_EN
            end else if (retn) begin
                iff1 <= iff2;
`endif
            end
        end
    end

    // EI shadow: set by an EI strobe inside an instruction, dropped at the boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ei_shadow <= 1'b0;
        else if (insn_end)
            ei_shadow <= 1'b0;
        else if (ei)
            ei_shadow <= 1'b1;
    end

    // Interrupt mode register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            im <= IM0;
        else if (im_set)
            im <= clamp_im(im_val);
    end

endmodule
